// File: rtl/scope_readout.sv
// scope_readout: drains a halted sample buffer into a framed byte stream
//   A5, samples..., 5A, count, [checksum], then pulses buf_reset to re-arm.
// Optional feature macro: SCOPE_READOUT_CKSUM_EN (appends the checksum byte).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              allows a new frame to start (looked at only in IDLE)
//   buf_done            buffer capture finished
//   buf_dout            sample at the buffer read pointer
//   buf_dout_ready      buffer holds at least one unread sample
//   buf_pop             one-cycle pulse advancing the buffer read pointer
//   buf_reset           one-cycle pulse re-arming the buffer
//   tx_data/tx_valid    byte stream towards the sink, tx_ready from the sink
//   busy                high whenever a frame is in progress
module scope_readout #(
    parameter int N     = 8,
    parameter int NSAMP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         buf_done,
    input  logic [N-1:0] buf_dout,
    input  logic         buf_dout_ready,
    output logic         buf_pop,
    output logic         buf_reset,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy
);
    if (N != 8 || NSAMP > 8) begin : g_bad_params
        $error("scope_readout: N must be 8 and NSAMP at most 8");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
    localparam logic [2:0] S_CNT   = 3'd5;
`ifdef SCOPE_READOUT_CKSUM_EN
    localparam logic [2:0] S_CKS   = 3'd6;
`endif
    localparam logic [2:0] S_REARM = 3'd7;

    logic [2:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       buf_pop_q, buf_pop_d;
    logic       buf_reset_q, buf_reset_d;
    logic       busy_q, busy_d;
    logic       xfer;
`ifdef SCOPE_READOUT_CKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    assign xfer = tx_valid_q & tx_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef SCOPE_READOUT_CKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                count_d = '0;
`ifdef SCOPE_READOUT_CKSUM_EN
                chk_d   = '0;
`endif
                state_d = (enable && buf_done) ? S_HDR : S_IDLE;
            end
            S_HDR:  state_d = xfer ? S_LOAD : S_HDR;
            // buf_pop_q was decided from buf_dout_ready on entry, so the pop
            // pulse and the sample latch always agree.
            S_LOAD: begin
                if (buf_pop_q) begin
                    count_d = count_q + 8'd1;
`ifdef SCOPE_READOUT_CKSUM_EN
                    chk_d   = chk_q ^ buf_dout;
`endif
                    state_d = S_SEND;
                end else begin
                    state_d = S_END;
                end
            end
            S_SEND: state_d = xfer ? S_LOAD : S_SEND;
            S_END:  state_d = xfer ? S_CNT : S_END;
`ifdef SCOPE_READOUT_CKSUM_EN
            S_CNT:  state_d = xfer ? S_CKS : S_CNT;
            S_CKS:  state_d = xfer ? S_REARM : S_CKS;
`else
            S_CNT:  state_d = xfer ? S_REARM : S_CNT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is valid for the
    // whole cycle spent in that state.
    always_comb begin
        tx_valid_d  = !(state_d == S_IDLE || state_d == S_LOAD || state_d == S_REARM);
        buf_pop_d   = (state_d == S_LOAD) && buf_dout_ready;
        buf_reset_d = (state_d == S_REARM);
        busy_d      = (state_d != S_IDLE);
        tx_data_d   = tx_data_q;
        case (state_d)
            S_HDR:  tx_data_d = 8'hA5;
            // tx_data_q doubles as the sample holding register
            S_SEND: tx_data_d = (state_q == S_LOAD) ? buf_dout : tx_data_q;
            S_END:  tx_data_d = 8'h5A;
            S_CNT:  tx_data_d = count_q;
`ifdef SCOPE_READOUT_CKSUM_EN
            S_CKS:  tx_data_d = chk_q ^ count_q;
`endif
            default: tx_data_d = tx_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            buf_pop_q   <= 1'b0;
            buf_reset_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            buf_pop_q   <= buf_pop_d;
            buf_reset_q <= buf_reset_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SCOPE_READOUT_CKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chk_q <= '0;
        else          chk_q <= chk_d;
    end
`endif

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign buf_pop   = buf_pop_q;
    assign buf_reset = buf_reset_q;
    assign busy      = busy_q;
endmodule
